// File: rtl/march_bist_ctrl.sv
// March C- sequencer for the SRAM BIST path.
// Steps the paired address counter through six March elements, issues one
// SRAM read or write per cycle, compares read data one cycle later and
// records the address and element of the first mismatching read.
module march_bist_ctrl #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] cnt_value,
  output logic                  cnt_en,
  output logic                  cnt_rst,
  output logic                  sram_ce,
  output logic                  sram_we,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_din,
  input  logic [DATA_WIDTH-1:0] sram_dout,
  output logic                  busy,
  output logic                  done,
  output logic                  fail,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [2:0]            fail_elem
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Index of the final element (E5, up: r0).
  localparam logic [2:0] LAST_ELEM = 3'd5;

  state_t                  r_state;
  logic [2:0]              r_elem;
  logic                    r_op;
  logic                    r_cmp_vld;
  logic                    r_cmp_exp;
  logic [ADDR_WIDTH-1:0]   r_cmp_addr;
  logic [2:0]              r_cmp_elem;
  logic                    r_fail;
  logic [ADDR_WIDTH-1:0]   r_fail_addr;
  logic [2:0]              r_fail_elem;

  logic                    w_we;
  logic                    w_bit;
  logic                    w_last;
  logic                    w_down;
  logic                    w_is_run;
  logic                    w_addr_last;
  logic                    w_mismatch;
  logic [ADDR_WIDTH-1:0]   w_addr;

  // Decode the current element/op into direction, access type, data bit and last-op flag.
  always_comb begin
    w_we   = 1'b0;
    w_bit  = 1'b0;
    w_last = 1'b1;
    w_down = 1'b0;
    case (r_elem)
      3'd0: begin            // up: w0
        w_we   = 1'b1;
        w_bit  = 1'b0;
        w_last = 1'b1;
      end
      3'd1: begin            // up: r0, w1
        w_we   = r_op;
        w_bit  = r_op;
        w_last = r_op;
      end
      3'd2: begin            // up: r1, w0
        w_we   = r_op;
        w_bit  = ~r_op;
        w_last = r_op;
      end
      3'd3: begin            // down: r0, w1
        w_down = 1'b1;
        w_we   = r_op;
        w_bit  = r_op;
        w_last = r_op;
      end
      3'd4: begin            // down: r1, w0
        w_down = 1'b1;
        w_we   = r_op;
        w_bit  = ~r_op;
        w_last = r_op;
      end
      3'd5: begin            // up: r0
        w_we   = 1'b0;
        w_bit  = 1'b0;
        w_last = 1'b1;
      end
      default: begin
        w_we   = 1'b0;
        w_bit  = 1'b0;
        w_last = 1'b1;
        w_down = 1'b0;
      end
    endcase
  end

  assign w_is_run    = (r_state == S_RUN);
  assign w_addr      = w_down ? ~cnt_value : cnt_value;
  assign w_addr_last = &cnt_value;
  // A read issued last cycle returns data now; compare against the replicated expected bit.
  assign w_mismatch  = r_cmp_vld && (sram_dout != {DATA_WIDTH{r_cmp_exp}});

  // All outputs decode directly from registered state; only the address follows the counter.
  assign sram_ce   = w_is_run;
  assign sram_we   = w_is_run && w_we;
  assign sram_addr = w_addr;
  assign sram_din  = {DATA_WIDTH{w_bit}};
  assign cnt_en    = w_is_run && w_last;
  assign cnt_rst   = (r_state == S_IDLE) || (r_state == S_DONE);
  assign busy      = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign done      = (r_state == S_DONE);
  assign fail      = r_fail;
  assign fail_addr = r_fail_addr;
  assign fail_elem = r_fail_elem;

  // Sequencer state, element/op position, read-compare pipeline and first-failure capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_elem      <= 3'd0;
      r_op        <= 1'b0;
      r_cmp_vld   <= 1'b0;
      r_cmp_exp   <= 1'b0;
      r_cmp_addr  <= '0;
      r_cmp_elem  <= 3'd0;
      r_fail      <= 1'b0;
      r_fail_addr <= '0;
      r_fail_elem <= 3'd0;
    end else begin
      // Every read in RUN becomes a compare entry for the next cycle.
      r_cmp_vld  <= w_is_run && !w_we;
      r_cmp_exp  <= w_bit;
      r_cmp_addr <= w_addr;
      r_cmp_elem <= r_elem;

      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_fail      <= 1'b0;
            r_fail_addr <= '0;
            r_fail_elem <= 3'd0;
            r_elem      <= 3'd0;
            r_op        <= 1'b0;
            r_state     <= S_RUN;
          end else begin
            r_state     <= r_state;
          end
        end
        S_RUN: begin
          if (w_mismatch) begin
            // The op issued this cycle still goes out; nothing after it does.
            r_fail      <= 1'b1;
            r_fail_addr <= r_cmp_addr;
            r_fail_elem <= r_cmp_elem;
            r_state     <= S_DONE;
          end else if (w_last) begin
            r_op <= 1'b0;
            if (w_addr_last) begin
              if (r_elem == LAST_ELEM) begin
                r_state <= S_DRAIN;
              end else begin
                r_elem  <= r_elem + 3'd1;
              end
            end else begin
              r_elem <= r_elem;
            end
          end else begin
            r_op <= 1'b1;
          end
        end
        S_DRAIN: begin
          // One cycle for the final read's compare.
          if (w_mismatch) begin
            r_fail      <= 1'b1;
            r_fail_addr <= r_cmp_addr;
            r_fail_elem <= r_cmp_elem;
          end else begin
            r_fail      <= r_fail;
          end
          r_state <= S_DONE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_march_bist_ctrl.sv
// Directed testbench for march_bist_ctrl with a 4-word x 8-bit SRAM model,
// an injectable stuck-at-0 fault and a behavioural address counter.
module tb_march_bist_ctrl;

  localparam int AW = 2;
  localparam int DW = 8;
  localparam int NOPS [6] = '{1, 2, 2, 2, 2, 1};
  localparam int DOWN [6] = '{0, 0, 0, 1, 1, 0};
  localparam int B0   [6] = '{0, 0, 1, 0, 1, 0};
  localparam int B1   [6] = '{0, 1, 0, 1, 0, 0};

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] cnt_value;
  logic          cnt_en, cnt_rst, sram_ce, sram_we;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_din;
  logic [DW-1:0] sram_dout;
  logic          busy, done, fail;
  logic [AW-1:0] fail_addr;
  logic [2:0]    fail_elem;

  logic          fault = 1'b0;
  logic [DW-1:0] mem [4];

  logic [AW-1:0] e_addr [40];
  logic          e_we   [40];
  logic          e_bit  [40];
  logic          e_cen  [40];
  int            e_elem [40];

  int n_checks = 0;
  int n_fail   = 0;

  march_bist_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .cnt_value(cnt_value),
    .cnt_en(cnt_en), .cnt_rst(cnt_rst), .sram_ce(sram_ce), .sram_we(sram_we),
    .sram_addr(sram_addr), .sram_din(sram_din), .sram_dout(sram_dout),
    .busy(busy), .done(done), .fail(fail), .fail_addr(fail_addr),
    .fail_elem(fail_elem)
  );

  always #5 clk = ~clk;

  // Paired address counter: sync active-high reset, increment on enable.
  always @(posedge clk) begin
    if (cnt_rst) cnt_value <= '0;
    else if (cnt_en) cnt_value <= cnt_value + 2'd1;
  end

  // Ideal 1-cycle-read SRAM; optional stuck-at-0 on bit 3 of address 2.
  always @(posedge clk) begin
    if (sram_ce) begin
      if (sram_we)
        mem[sram_addr] <= (fault && sram_addr == 2'd2) ? (sram_din & 8'hF7) : sram_din;
      else
        sram_dout <= (fault && sram_addr == 2'd2) ? (mem[sram_addr] & 8'hF7) : mem[sram_addr];
    end
  end

  // Expected op stream of a clean March C- run over 4 addresses.
  task automatic build_table();
    int idx;
    idx = 0;
    for (int e = 0; e < 6; e++) begin
      for (int a = 0; a < 4; a++) begin
        for (int k = 0; k < NOPS[e]; k++) begin
          e_addr[idx] = AW'((DOWN[e] != 0) ? (3 - a) : a);
          e_we[idx]   = (e == 0) || (k == 1);
          e_bit[idx]  = (k == 0) ? (B0[e] != 0) : (B1[e] != 0);
          e_cen[idx]  = (k == NOPS[e] - 1);
          e_elem[idx] = e;
          idx++;
        end
      end
    end
  endtask

  // Issue a one-cycle start pulse; returns at the negedge of the first RUN cycle.
  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    n_checks++; if (sram_ce !== 1'b0) begin n_fail++; $display("FAIL reset_ce: got %b expected 0", sram_ce); end
    n_checks++; if (cnt_en !== 1'b0) begin n_fail++; $display("FAIL reset_cnt_en: got %b expected 0", cnt_en); end
    n_checks++; if (cnt_rst !== 1'b1) begin n_fail++; $display("FAIL reset_cnt_rst: got %b expected 1", cnt_rst); end
    n_checks++; if (fail !== 1'b0) begin n_fail++; $display("FAIL reset_fail: got %b expected 0", fail); end
    n_checks++; if (fail_addr !== 2'd0) begin n_fail++; $display("FAIL reset_fail_addr: got %0d expected 0", fail_addr); end
    n_checks++; if (fail_elem !== 3'd0) begin n_fail++; $display("FAIL reset_fail_elem: got %0d expected 0", fail_elem); end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (busy !== 1'b0 || sram_ce !== 1'b0 || cnt_rst !== 1'b1) begin
      n_fail++; $display("FAIL idle_after_reset: busy=%b ce=%b cnt_rst=%b expected 0 0 1", busy, sram_ce, cnt_rst);
    end
  endtask

  task automatic test_clean_run();
    int cen_cnt [6];
    for (int e = 0; e < 6; e++) cen_cnt[e] = 0;
    pulse_start();
    for (int i = 0; i < 40; i++) begin
      n_checks++; if (sram_ce !== 1'b1) begin n_fail++; $display("FAIL clean_ce[%0d]: got %b expected 1", i, sram_ce); end
      n_checks++; if (sram_addr !== e_addr[i]) begin n_fail++; $display("FAIL clean_addr[%0d]: got %0d expected %0d", i, sram_addr, e_addr[i]); end
      n_checks++; if (sram_we !== e_we[i]) begin n_fail++; $display("FAIL clean_we[%0d]: got %b expected %b", i, sram_we, e_we[i]); end
      n_checks++; if (cnt_en !== e_cen[i]) begin n_fail++; $display("FAIL clean_cnt_en[%0d]: got %b expected %b", i, cnt_en, e_cen[i]); end
      if (e_we[i]) begin
        n_checks++; if (sram_din !== {DW{e_bit[i]}}) begin n_fail++; $display("FAIL clean_din[%0d]: got %h expected %h", i, sram_din, {DW{e_bit[i]}}); end
      end
      if (i == 5) begin
        n_checks++; if (sram_dout !== 8'h00) begin n_fail++; $display("FAIL e1_r0_data: got %h expected 00", sram_dout); end
        n_checks++; if (sram_din !== 8'hFF || sram_we !== 1'b1) begin n_fail++; $display("FAIL e1_w1: din=%h we=%b expected FF 1", sram_din, sram_we); end
      end
      if (i == 20) begin
        n_checks++; if (sram_addr !== 2'd3) begin n_fail++; $display("FAIL e3_start_addr: got %0d expected 3", sram_addr); end
      end
      if (cnt_en === 1'b1) cen_cnt[e_elem[i]]++;
      @(negedge clk);
    end
    n_checks++; if (sram_ce !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
      n_fail++; $display("FAIL clean_drain: ce=%b busy=%b done=%b expected 0 1 0", sram_ce, busy, done);
    end
    @(negedge clk);
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL clean_done: got %b expected 1", done); end
    n_checks++; if (fail !== 1'b0) begin n_fail++; $display("FAIL clean_fail: got %b expected 0", fail); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL clean_busy: got %b expected 0", busy); end
    for (int e = 0; e < 6; e++) begin
      n_checks++; if (cen_cnt[e] != 4) begin n_fail++; $display("FAIL cnt_en_pulses[E%0d]: got %0d expected 4", e, cen_cnt[e]); end
    end
    repeat (3) @(negedge clk);
    n_checks++; if (done !== 1'b1 || sram_ce !== 1'b0 || cnt_rst !== 1'b1) begin
      n_fail++; $display("FAIL done_hold: done=%b ce=%b cnt_rst=%b expected 1 0 1", done, sram_ce, cnt_rst);
    end
  endtask

  task automatic test_stuck_fault();
    fault = 1'b1;
    pulse_start();
    for (int i = 0; i < 18; i++) begin
      n_checks++; if (done !== 1'b0 || sram_ce !== 1'b1) begin
        n_fail++; $display("FAIL stuck_running[%0d]: done=%b ce=%b expected 0 1", i, done, sram_ce);
      end
      if (i == 16) begin
        n_checks++; if (sram_we !== 1'b0 || sram_addr !== 2'd2) begin
          n_fail++; $display("FAIL stuck_read_op: we=%b addr=%0d expected 0 2", sram_we, sram_addr);
        end
      end
      @(negedge clk);
    end
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL stuck_done: got %b expected 1", done); end
    n_checks++; if (fail !== 1'b1) begin n_fail++; $display("FAIL stuck_fail: got %b expected 1", fail); end
    n_checks++; if (fail_addr !== 2'd2) begin n_fail++; $display("FAIL stuck_fail_addr: got %0d expected 2", fail_addr); end
    n_checks++; if (fail_elem !== 3'd2) begin n_fail++; $display("FAIL stuck_fail_elem: got %0d expected 2", fail_elem); end
    n_checks++; if (sram_ce !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL stuck_idle_ops: ce=%b busy=%b expected 0 0", sram_ce, busy); end
    repeat (4) @(negedge clk);
    n_checks++; if (done !== 1'b1 || fail !== 1'b1 || fail_addr !== 2'd2 || fail_elem !== 3'd2) begin
      n_fail++; $display("FAIL stuck_hold: done=%b fail=%b addr=%0d elem=%0d expected 1 1 2 2", done, fail, fail_addr, fail_elem);
    end
  endtask

  task automatic test_back_to_back();
    int nce;
    fault = 1'b0;
    nce = 0;
    pulse_start();
    n_checks++; if (fail !== 1'b0 || fail_addr !== 2'd0 || fail_elem !== 3'd0) begin
      n_fail++; $display("FAIL b2b_fail_clear: fail=%b addr=%0d elem=%0d expected 0 0 0", fail, fail_addr, fail_elem);
    end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy: got %b expected 1", busy); end
    for (int i = 0; i < 40; i++) begin
      if (sram_ce === 1'b1) nce++;
      @(negedge clk);
    end
    n_checks++; if (nce != 40) begin n_fail++; $display("FAIL b2b_op_count: got %0d expected 40", nce); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL b2b_done_early: got %b expected 0", done); end
    @(negedge clk);
    n_checks++; if (done !== 1'b1 || fail !== 1'b0) begin
      n_fail++; $display("FAIL b2b_done: done=%b fail=%b expected 1 0", done, fail);
    end
  endtask

  task automatic test_start_during_run();
    pulse_start();
    for (int i = 0; i < 40; i++) begin
      n_checks++; if (sram_ce !== 1'b1 || sram_addr !== e_addr[i] || sram_we !== e_we[i]) begin
        n_fail++; $display("FAIL start_run_op[%0d]: ce=%b addr=%0d we=%b expected 1 %0d %b", i, sram_ce, sram_addr, sram_we, e_addr[i], e_we[i]);
      end
      start = ((i >= 3) && (i <= 10)) || (i == 20);
      @(negedge clk);
    end
    start = 1'b0;
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL start_run_done_early: got %b expected 0", done); end
    @(negedge clk);
    n_checks++; if (done !== 1'b1 || fail !== 1'b0) begin
      n_fail++; $display("FAIL start_run_done: done=%b fail=%b expected 1 0", done, fail);
    end
  endtask

  task automatic test_reset_mid_run();
    int nce;
    nce = 0;
    pulse_start();
    repeat (15) @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++; if (sram_ce !== 1'b0) begin n_fail++; $display("FAIL midrst_ce: got %b expected 0", sram_ce); end
    n_checks++; if (cnt_rst !== 1'b1) begin n_fail++; $display("FAIL midrst_cnt_rst: got %b expected 1", cnt_rst); end
    n_checks++; if (busy !== 1'b0 || done !== 1'b0 || cnt_en !== 1'b0) begin
      n_fail++; $display("FAIL midrst_status: busy=%b done=%b cnt_en=%b expected 0 0 0", busy, done, cnt_en);
    end
    @(negedge clk);
    n_checks++; if (cnt_value !== 2'd0 || sram_ce !== 1'b0) begin
      n_fail++; $display("FAIL midrst_hold: cnt=%0d ce=%b expected 0 0", cnt_value, sram_ce);
    end
    rst = 1'b1;
    pulse_start();
    for (int i = 0; i < 40; i++) begin
      if (sram_ce === 1'b1 && sram_addr === e_addr[i]) nce++;
      @(negedge clk);
    end
    n_checks++; if (nce != 40) begin n_fail++; $display("FAIL midrst_rerun_ops: got %0d expected 40", nce); end
    @(negedge clk);
    n_checks++; if (done !== 1'b1 || fail !== 1'b0) begin
      n_fail++; $display("FAIL midrst_rerun_done: done=%b fail=%b expected 1 0", done, fail);
    end
  endtask

  initial begin
    build_table();
    test_reset();
    test_clean_run();
    test_stuck_fault();
    test_back_to_back();
    test_start_during_run();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
